// File: rtl/ahbl_arbiter.sv
// ----------------------------------------------------------------------------
// ahbl_arbiter
//
// AHB-lite N:1 fixed-priority arbiter. Several upstream masters share one
// downstream slave bus; the lowest port index wins. An address phase that
// loses arbitration is parked in a per-port buffer and the owning master is
// held in its data phase (HREADYOUT low) until the parked transfer has been
// issued downstream and its data phase has completed.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   src_hready[N]         per-port bus HREADY (tie to src_hready_resp for a
//                         true master)
//   src_hready_resp[N]    per-port HREADYOUT
//   src_hresp[N]          per-port HRESP
//   src_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hwdata
//                         per-port address/control and write data, packed
//                         with port 0 in the least significant slice
//   src_hrdata            downstream HRDATA broadcast to every port
//   dst_hready            downstream HREADY (equal to dst_hready_resp)
//   dst_hready_resp       slave HREADYOUT
//   dst_hresp             slave HRESP
//   dst_haddr..dst_hmastlock  muxed address phase
//   dst_hwdata            write data of the current data-phase owner
//   dst_hrdata            slave read data
// ----------------------------------------------------------------------------
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [N_PORTS-1:0]          src_hready,
    output logic [N_PORTS-1:0]          src_hready_resp,
    output logic [N_PORTS-1:0]          src_hresp,
    input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS-1:0]          src_hwrite,
    input  logic [N_PORTS*2-1:0]        src_htrans,
    input  logic [N_PORTS*3-1:0]        src_hsize,
    input  logic [N_PORTS*3-1:0]        src_hburst,
    input  logic [N_PORTS*4-1:0]        src_hprot,
    input  logic [N_PORTS-1:0]          src_hmastlock,
    input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
    output logic [N_PORTS*W_DATA-1:0]   src_hrdata,

    output logic                        dst_hready,
    input  logic                        dst_hready_resp,
    input  logic                        dst_hresp,
    output logic [W_ADDR-1:0]           dst_haddr,
    output logic                        dst_hwrite,
    output logic [1:0]                  dst_htrans,
    output logic [2:0]                  dst_hsize,
    output logic [2:0]                  dst_hburst,
    output logic [3:0]                  dst_hprot,
    output logic                        dst_hmastlock,
    output logic [W_DATA-1:0]           dst_hwdata,
    input  logic [W_DATA-1:0]           dst_hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam int         W_IDX         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    // State
    logic [N_PORTS-1:0]  buf_valid_q, buf_valid_d;
    logic [W_ADDR-1:0]   buf_haddr_q [N_PORTS];
    logic [N_PORTS-1:0]  buf_hwrite_q;
    logic [2:0]          buf_hsize_q [N_PORTS];
    logic [2:0]          buf_hburst_q [N_PORTS];
    logic [3:0]          buf_hprot_q [N_PORTS];
    logic [N_PORTS-1:0]  buf_hmastlock_q;
    logic [N_PORTS-1:0]  mst_sel_q;      // one-hot data-phase owner, 0 = idle
    logic                lock_hold_q;
    logic [W_IDX-1:0]    lock_owner_q;

    // Per-port request and effective address phase
    logic [N_PORTS-1:0]  live_req;
    logic [N_PORTS-1:0]  live_capt;
    logic [N_PORTS-1:0]  req;
    logic [N_PORTS-1:0]  capt;
    logic [N_PORTS-1:0]  accepted;
    logic [W_ADDR-1:0]   a_haddr [N_PORTS];
    logic [N_PORTS-1:0]  a_hwrite;
    logic [1:0]          a_htrans [N_PORTS];
    logic [2:0]          a_hsize [N_PORTS];
    logic [2:0]          a_hburst [N_PORTS];
    logic [3:0]          a_hprot [N_PORTS];
    logic [N_PORTS-1:0]  a_hmastlock;

    // Grant
    logic [N_PORTS-1:0]  grant_vec;
    logic                grant_any;
    logic [W_IDX-1:0]    grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign live_req[gi]  = src_hready[gi] & (src_htrans[gi*2 +: 2] != HTRANS_IDLE);
            // Only NONSEQ/SEQ (htrans[1] set) are real transfers worth parking;
            // IDLE and BUSY are never buffered.
            assign live_capt[gi] = src_hready[gi] & src_htrans[gi*2+1];
            // Requests are masked while reset is asserted so the bus shows IDLE.
            assign req[gi]       = rst_n & (buf_valid_q[gi] | live_req[gi]);

            assign a_haddr[gi]     = buf_valid_q[gi] ? buf_haddr_q[gi]     : src_haddr[gi*W_ADDR +: W_ADDR];
            assign a_hwrite[gi]    = buf_valid_q[gi] ? buf_hwrite_q[gi]    : src_hwrite[gi];
            // A parked transfer has lost its place in any burst, so it always
            // restarts as NONSEQ.
            assign a_htrans[gi]    = buf_valid_q[gi] ? HTRANS_NONSEQ       : src_htrans[gi*2 +: 2];
            assign a_hsize[gi]     = buf_valid_q[gi] ? buf_hsize_q[gi]     : src_hsize[gi*3 +: 3];
            assign a_hburst[gi]    = buf_valid_q[gi] ? buf_hburst_q[gi]    : src_hburst[gi*3 +: 3];
            assign a_hprot[gi]     = buf_valid_q[gi] ? buf_hprot_q[gi]     : src_hprot[gi*4 +: 4];
            assign a_hmastlock[gi] = buf_valid_q[gi] ? buf_hmastlock_q[gi] : src_hmastlock[gi];

            assign accepted[gi] = dst_hready_resp & grant_vec[gi];
            // A live request that is not taken downstream this cycle is parked.
            // While stalled the master's src_hready is low, so a port never
            // re-captures over an existing buffer.
            assign capt[gi]        = live_capt[gi] & ~buf_valid_q[gi] & ~accepted[gi];
            assign buf_valid_d[gi] = capt[gi] | (buf_valid_q[gi] & ~accepted[gi]);

            assign src_hready_resp[gi] = mst_sel_q[gi] ? dst_hready_resp : ~buf_valid_q[gi];
            assign src_hresp[gi]       = mst_sel_q[gi] & dst_hresp;
            assign src_hrdata[gi*W_DATA +: W_DATA] = dst_hrdata;
        end
    endgenerate

    // Fixed-priority grant; a locked sequence keeps the bus on its owner and
    // leaves it idle if the owner pauses.
    always_comb begin
        grant_vec = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (lock_hold_q) begin
            if (req[lock_owner_q]) begin
                grant_any               = 1'b1;
                grant_idx               = lock_owner_q;
                grant_vec[lock_owner_q] = 1'b1;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (req[i] && !grant_any) begin
                    grant_any    = 1'b1;
                    grant_idx    = W_IDX'(i);
                    grant_vec[i] = 1'b1;
                end
            end
        end
    end

    // Downstream address phase
    always_comb begin
        dst_haddr     = src_haddr[W_ADDR-1:0];
        dst_hwrite    = src_hwrite[0];
        dst_htrans    = HTRANS_IDLE;
        dst_hsize     = src_hsize[2:0];
        dst_hburst    = src_hburst[2:0];
        dst_hprot     = src_hprot[3:0];
        dst_hmastlock = src_hmastlock[0];
        if (grant_any) begin
            dst_haddr     = a_haddr[grant_idx];
            dst_hwrite    = a_hwrite[grant_idx];
            dst_htrans    = a_htrans[grant_idx];
            dst_hsize     = a_hsize[grant_idx];
            dst_hburst    = a_hburst[grant_idx];
            dst_hprot     = a_hprot[grant_idx];
            dst_hmastlock = a_hmastlock[grant_idx];
        end
    end

    // Write data follows the data-phase owner
    always_comb begin
        dst_hwdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (mst_sel_q[i]) begin
                dst_hwdata = dst_hwdata | src_hwdata[i*W_DATA +: W_DATA];
            end
        end
    end

    assign dst_hready = dst_hready_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q  <= '0;
            mst_sel_q    <= '0;
            lock_hold_q  <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            if (dst_hready_resp) begin
                mst_sel_q    <= grant_vec;
                lock_hold_q  <= grant_any & dst_hmastlock;
                lock_owner_q <= grant_idx;
            end
        end
    end

    // Buffer payload needs no reset: it is only observed while buf_valid_q is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (capt[i]) begin
                buf_haddr_q[i]     <= src_haddr[i*W_ADDR +: W_ADDR];
                buf_hwrite_q[i]    <= src_hwrite[i];
                buf_hsize_q[i]     <= src_hsize[i*3 +: 3];
                buf_hburst_q[i]    <= src_hburst[i*3 +: 3];
                buf_hprot_q[i]     <= src_hprot[i*4 +: 4];
                buf_hmastlock_q[i] <= src_hmastlock[i];
            end
        end
    end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahbl_arbiter
//
// Directed bench for ahbl_arbiter with two ports. Stimulus pushes the expected
// downstream address phases and write data into queues; a monitor on the
// falling edge pops and compares whenever the downstream bus accepts an
// address phase or completes a write data phase. Per-port response signals
// and reset behaviour are compared inline.
// ----------------------------------------------------------------------------
module tb_ahbl_arbiter;

    localparam int N  = 2;
    localparam int WA = 32;
    localparam int WD = 32;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      src_hready;
    logic [N-1:0]      src_hready_resp;
    logic [N-1:0]      src_hresp;
    logic [N*WA-1:0]   src_haddr;
    logic [N-1:0]      src_hwrite;
    logic [N*2-1:0]    src_htrans;
    logic [N*3-1:0]    src_hsize;
    logic [N*3-1:0]    src_hburst;
    logic [N*4-1:0]    src_hprot;
    logic [N-1:0]      src_hmastlock;
    logic [N*WD-1:0]   src_hwdata;
    logic [N*WD-1:0]   src_hrdata;
    logic              dst_hready;
    logic              dst_hready_resp;
    logic              dst_hresp;
    logic [WA-1:0]     dst_haddr;
    logic              dst_hwrite;
    logic [1:0]        dst_htrans;
    logic [2:0]        dst_hsize;
    logic [2:0]        dst_hburst;
    logic [3:0]        dst_hprot;
    logic              dst_hmastlock;
    logic [WD-1:0]     dst_hwdata;
    logic [WD-1:0]     dst_hrdata;

    // Per-port master drive
    logic [WA-1:0] p_addr  [N];
    logic          p_write [N];
    logic [1:0]    p_trans [N];
    logic [2:0]    p_size  [N];
    logic          p_lock  [N];
    logic [WD-1:0] p_wdata [N];

    assign src_hready    = src_hready_resp;   // true masters
    assign src_haddr     = {p_addr[1], p_addr[0]};
    assign src_hwrite    = {p_write[1], p_write[0]};
    assign src_htrans    = {p_trans[1], p_trans[0]};
    assign src_hsize     = {p_size[1], p_size[0]};
    assign src_hburst    = '0;
    assign src_hprot     = {4'b0011, 4'b0011};
    assign src_hmastlock = {p_lock[1], p_lock[0]};
    assign src_hwdata    = {p_wdata[1], p_wdata[0]};

    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_hready      (src_hready),
        .src_hready_resp (src_hready_resp),
        .src_hresp       (src_hresp),
        .src_haddr       (src_haddr),
        .src_hwrite      (src_hwrite),
        .src_htrans      (src_htrans),
        .src_hsize       (src_hsize),
        .src_hburst      (src_hburst),
        .src_hprot       (src_hprot),
        .src_hmastlock   (src_hmastlock),
        .src_hwdata      (src_hwdata),
        .src_hrdata      (src_hrdata),
        .dst_hready      (dst_hready),
        .dst_hready_resp (dst_hready_resp),
        .dst_hresp       (dst_hresp),
        .dst_haddr       (dst_haddr),
        .dst_hwrite      (dst_hwrite),
        .dst_htrans      (dst_htrans),
        .dst_hsize       (dst_hsize),
        .dst_hburst      (dst_hburst),
        .dst_hprot       (dst_hprot),
        .dst_hmastlock   (dst_hmastlock),
        .dst_hwdata      (dst_hwdata),
        .dst_hrdata      (dst_hrdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WA-1:0] addr;
        logic          write;
        logic [1:0]    trans;
        logic [2:0]    size;
    } aphase_t;

    aphase_t       exp_a [$];
    logic [WD-1:0] exp_w [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input int p, input logic [1:0] tr, input logic [WA-1:0] a,
                         input logic w, input logic [2:0] sz, input logic lk);
        p_trans[p] = tr;
        p_addr[p]  = a;
        p_write[p] = w;
        p_size[p]  = sz;
        p_lock[p]  = lk;
    endtask

    task automatic idle_all();
        drive(0, IDLE, '0, 1'b0, 3'd2, 1'b0);
        drive(1, IDLE, '0, 1'b0, 3'd2, 1'b0);
    endtask

    task automatic expect_a(input logic [WA-1:0] a, input logic w, input logic [1:0] tr,
                            input logic [2:0] sz);
        aphase_t e;
        e.addr = a; e.write = w; e.trans = tr; e.size = sz;
        exp_a.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: downstream data-phase and address-phase scoreboard
    logic dph_v = 1'b0;
    logic dph_w = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dph_v = 1'b0;
            end else if (dst_hready) begin
                if (dph_v && dph_w) begin
                    if (exp_w.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wdata_unexpected actual=%h required=none", dst_hwdata);
                    end else begin
                        logic [WD-1:0] ew;
                        ew = exp_w.pop_front();
                        $display("wdata %h", dst_hwdata);
                        check("wdata", dst_hwdata, ew);
                    end
                end
                if (dst_htrans[1]) begin
                    if (exp_a.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aphase_unexpected actual=%h required=none", dst_haddr);
                    end else begin
                        aphase_t ea;
                        ea = exp_a.pop_front();
                        $display("aphase addr=%h write=%0d trans=%0d size=%0d",
                                 dst_haddr, dst_hwrite, dst_htrans, dst_hsize);
                        check("aphase", {dst_haddr, dst_hwrite, dst_htrans, dst_hsize},
                              {ea.addr, ea.write, ea.trans, ea.size});
                    end
                end
                dph_v = dst_htrans[1];
                dph_w = dst_hwrite;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_all();
        p_wdata[0] = '0;
        p_wdata[1] = '0;
        dst_hready_resp = 1'b1;
        dst_hresp  = 1'b0;
        dst_hrdata = '0;

        // Reset state
        mid();
        check("rst_hready_resp", src_hready_resp, 2'b11);
        check("rst_hresp", src_hresp, 2'b00);
        check("rst_dst_htrans", dst_htrans, IDLE);
        check("rst_dst_hwdata", dst_hwdata, 32'h0);
        next();
        rst_n = 1'b1;
        next();

        // 1: single read with one wait state
        drive(0, NONSEQ, 32'h1000, 1'b0, 3'd2, 1'b0);
        expect_a(32'h1000, 1'b0, NONSEQ, 3'd2);
        mid();
        check("t1_dst_htrans", dst_htrans, NONSEQ);
        next();
        idle_all();
        dst_hready_resp = 1'b0;
        mid();
        check("t1_resp0_wait", src_hready_resp[0], 1'b0);
        next();
        dst_hready_resp = 1'b1;
        dst_hrdata = 32'hCAFEF00D;
        mid();
        check("t1_resp0_done", src_hready_resp[0], 1'b1);
        check("t1_hrdata0", src_hrdata[31:0], 32'hCAFEF00D);
        check("t1_hrdata1", src_hrdata[63:32], 32'hCAFEF00D);
        next();
        dst_hrdata = '0;

        // 2: simultaneous writes, port 1 buffered
        p_wdata[0] = 32'h11111111;
        p_wdata[1] = 32'h22222222;
        drive(0, NONSEQ, 32'h10, 1'b1, 3'd2, 1'b0);
        drive(1, NONSEQ, 32'h20, 1'b1, 3'd2, 1'b0);
        expect_a(32'h10, 1'b1, NONSEQ, 3'd2);
        expect_a(32'h20, 1'b1, NONSEQ, 3'd2);
        exp_w.push_back(32'h11111111);
        exp_w.push_back(32'h22222222);
        mid();
        check("t2_first_addr", dst_haddr, 32'h10);
        next();
        idle_all();
        mid();
        check("t2_resp1_buffered", src_hready_resp[1], 1'b0);
        check("t2_second_addr", dst_haddr, 32'h20);
        next();
        dst_hready_resp = 1'b0;
        mid();
        check("t2_resp1_wait", src_hready_resp[1], 1'b0);
        next();
        dst_hready_resp = 1'b1;
        mid();
        check("t2_resp1_done", src_hready_resp[1], 1'b1);
        next();

        // 3: locked sequence on port 1, port 0 parked
        drive(1, NONSEQ, 32'h100, 1'b0, 3'd2, 1'b1);
        expect_a(32'h100, 1'b0, NONSEQ, 3'd2);
        next();
        drive(1, SEQ, 32'h104, 1'b0, 3'd2, 1'b1);
        drive(0, NONSEQ, 32'h200, 1'b0, 3'd2, 1'b0);
        expect_a(32'h104, 1'b0, SEQ, 3'd2);
        mid();
        check("t3_dst_lock", dst_hmastlock, 1'b1);
        next();
        drive(1, SEQ, 32'h108, 1'b0, 3'd2, 1'b1);
        drive(0, IDLE, '0, 1'b0, 3'd2, 1'b0);
        expect_a(32'h108, 1'b0, SEQ, 3'd2);
        mid();
        check("t3_resp0_stalled", src_hready_resp[0], 1'b0);
        next();
        drive(1, IDLE, '0, 1'b0, 3'd2, 1'b0);
        mid();
        check("t3_lock_gap_htrans", dst_htrans, IDLE);
        check("t3_resp0_still", src_hready_resp[0], 1'b0);
        next();
        expect_a(32'h200, 1'b0, NONSEQ, 3'd2);
        mid();
        check("t3_port0_issued", dst_haddr, 32'h200);
        next();
        mid();
        check("t3_resp0_done", src_hready_resp[0], 1'b1);
        next();

        // 4: ERROR response on port 1
        p_wdata[1] = 32'h33333333;
        drive(1, NONSEQ, 32'h300, 1'b1, 3'd2, 1'b0);
        expect_a(32'h300, 1'b1, NONSEQ, 3'd2);
        exp_w.push_back(32'h33333333);
        next();
        idle_all();
        dst_hready_resp = 1'b0;
        dst_hresp = 1'b1;
        mid();
        check("t4_err1_resp", {src_hready_resp[1], src_hresp[1]}, 2'b01);
        check("t4_port0_quiet", {src_hready_resp[0], src_hresp[0]}, 2'b10);
        next();
        dst_hready_resp = 1'b1;
        mid();
        check("t4_err2_resp", {src_hready_resp[1], src_hresp[1]}, 2'b11);
        check("t4_port0_hresp", src_hresp[0], 1'b0);
        next();
        dst_hresp = 1'b0;

        // 5: buffered SEQ issued as NONSEQ
        p_wdata[1] = 32'h55555555;
        drive(0, NONSEQ, 32'h400, 1'b0, 3'd2, 1'b0);
        drive(1, SEQ, 32'h504, 1'b1, 3'd1, 1'b0);
        expect_a(32'h400, 1'b0, NONSEQ, 3'd2);
        expect_a(32'h504, 1'b1, NONSEQ, 3'd1);
        exp_w.push_back(32'h55555555);
        next();
        idle_all();
        mid();
        check("t5_seq_as_nonseq", dst_htrans, NONSEQ);
        check("t5_size", dst_hsize, 3'd1);
        next();
        next();

        // 6: reset while port 1 is buffered
        drive(0, NONSEQ, 32'h600, 1'b0, 3'd2, 1'b0);
        drive(1, NONSEQ, 32'h700, 1'b0, 3'd2, 1'b0);
        expect_a(32'h600, 1'b0, NONSEQ, 3'd2);
        next();
        idle_all();
        rst_n = 1'b0;
        mid();
        check("t6_rst_resp", src_hready_resp, 2'b11);
        check("t6_rst_htrans", dst_htrans, IDLE);
        check("t6_rst_hwdata", dst_hwdata, 32'h0);
        next();
        mid();
        check("t6_rst_resp_hold", src_hready_resp, 2'b11);
        next();
        rst_n = 1'b1;
        mid();
        check("t6_post_resp", src_hready_resp, 2'b11);
        check("t6_post_htrans", dst_htrans, IDLE);
        next();
        mid();
        check("t6_post_htrans2", dst_htrans, IDLE);
        next();

        check("aphase_queue_empty", exp_a.size(), 0);
        check("wdata_queue_empty", exp_w.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
